// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcode encodings, hazard FSM states and operand-usage helpers.
// Used by hazard_ctrl and hazard_detect; performance counters are gated by HAZARD_PERF_EN.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        ADDIU = 6'h09,
        SLTI  = 6'h0A,
        SLTIU = 6'h0B,
        ANDI  = 6'h0C,
        ORI   = 6'h0D,
        XORI  = 6'h0E,
        LUI   = 6'h0F,
        LB    = 6'h20,
        LH    = 6'h21,
        LW    = 6'h23,
        LBU   = 6'h24,
        LHU   = 6'h25,
        SB    = 6'h28,
        SH    = 6'h29,
        SW    = 6'h2B
    } opcode_t;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hazard_state_t;

    // I-type ALU ops, loads and stores only consume rs; stores also consume rt.
    function automatic logic reads_rs(input logic [5:0] opcode);
        case (opcode)
            RTYPE, BEQ, BNE,
            ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI,
            LB, LH, LW, LBU, LHU,
            SB, SH, SW:             return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rt(input logic [5:0] opcode);
        case (opcode)
            RTYPE, BEQ, BNE,
            SB, SH, SW:             return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of hazard-controller signals between datapath and hazard_ctrl.
// The counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic             nRST;
    logic [5:0]       id_opcode;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_lw;
    logic [REG_W-1:0] ex_wsel;
    logic             ex_pcsrc;
    logic             ihit;
    logic             mem_dreq;
    logic             dhit;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    modport hu (
        input  nRST, id_opcode, id_rs, id_rt, ex_lw, ex_wsel, ex_pcsrc,
        input  ihit, mem_dreq, dhit,
`ifdef HAZARD_PERF_EN
        output stall_cnt, flush_cnt,
`endif
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use dependency check between the ID instruction and a load in EX.
// Register 0 is hard-wired, so it never creates a dependency.
module hazard_detect
    import cpu_types_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [5:0]       id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_lw,
    input  logic [REG_W-1:0] ex_wsel,
    output logic             lu_hit
);

    logic rsDep;
    logic rtDep;

    always_comb begin
        rsDep  = reads_rs(id_opcode) && (id_rs != '0) && (id_rs == ex_wsel);
        rtDep  = reads_rt(id_opcode) && (id_rt != '0) && (id_rt == ex_wsel);
        lu_hit = ex_lw && (rsDep || rtDep);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, data-memory wait freeze, branch squash.
// Define HAZARD_PERF_EN to add the saturating stall_cnt / flush_cnt counters.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [5:0]       id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_lw,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic             ex_pcsrc,
    input  logic             ihit,
    input  logic             mem_dreq,
    input  logic             dhit,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int CW = $clog2(LOAD_LAT + 1);

    hazard_state_t state;
    hazard_state_t nextState;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nextCnt;
    logic          luHit;
    logic          dWait;
    logic          luStall;

    hazard_detect #(
        .REG_W (REG_W)
    ) uDetect (
        .id_opcode (id_opcode),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .ex_lw     (ex_lw),
        .ex_wsel   (ex_wsel),
        .lu_hit    (luHit)
    );

    assign dWait   = mem_dreq && !dhit;
    assign luStall = ((state == RUN) && luHit) || (state == LU_STALL);

    // Priority chain: reset, memory wait, redirect, load-use, fetch miss, normal.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        nextState  = state;
        nextCnt    = cnt;

        if (!nRST) begin
            nextState = RUN;
            nextCnt   = '0;
        end else if (dWait) begin
            nextState = state;
            nextCnt   = cnt;
        end else if (ex_pcsrc) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            nextState  = RUN;
            nextCnt    = '0;
        end else begin
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (luStall) begin
                idex_flush = 1'b1;
            end else if (!ihit) begin
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end

            // The first stall cycle is spent in RUN, so LU_STALL covers LOAD_LAT-1 more.
            case (state)
                RUN: begin
                    if (luHit && (LOAD_LAT > 1)) begin
                        nextState = LU_STALL;
                        nextCnt   = CW'(LOAD_LAT - 1);
                    end
                end
                LU_STALL: begin
                    if (cnt <= CW'(1)) begin
                        nextState = RUN;
                        nextCnt   = '0;
                    end else begin
                        nextCnt = cnt - CW'(1);
                    end
                end
                default: begin
                    nextState = RUN;
                    nextCnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

`ifdef HAZARD_PERF_EN
    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ex_pcsrc && !dWait && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with LOAD_LAT=1 and LOAD_LAT=3 instances.
// Counter checks (including CNT_W=2 saturation) are compiled in with HAZARD_PERF_EN.
module tb_hazard_ctrl;
    import cpu_types_pkg::*;

    localparam logic [6:0] NORMAL = 7'b11111_00;
    localparam logic [6:0] LUSTL  = 7'b00111_01;
    localparam logic [6:0] DWAIT  = 7'b00000_00;
    localparam logic [6:0] FLUSH  = 7'b11111_11;
    localparam logic [6:0] FMISS  = 7'b01111_10;
    localparam logic [6:0] RESET  = 7'b00000_00;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, ex_wsel;
    logic       ex_lw, ex_pcsrc, ihit, mem_dreq, dhit;

    logic pc1, ifid1, idex1, exmem1, memwb1, ifidF1, idexF1;
    logic pc3, ifid3, idex3, exmem3, memwb3, ifidF3, idexF3;
    logic [6:0] outs1, outs3;

    int compareCount  = 0;
    int mismatchCount = 0;

`ifdef HAZARD_PERF_EN
    logic [31:0] stallCnt1, flushCnt1, stallCnt3, flushCnt3;
    logic [1:0]  stallCntS, flushCntS;
    logic pcS, ifidS, idexS, exmemS, memwbS, ifidFS, idexFS;
`endif

    always #5 CLK = ~CLK;

    assign outs1 = {pc1, ifid1, idex1, exmem1, memwb1, ifidF1, idexF1};
    assign outs3 = {pc3, ifid3, idex3, exmem3, memwb3, ifidF3, idexF3};

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(32)) dut1 (
        .CLK(CLK), .nRST(nRST), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_lw(ex_lw), .ex_wsel(ex_wsel), .ex_pcsrc(ex_pcsrc), .ihit(ihit),
        .mem_dreq(mem_dreq), .dhit(dhit), .pc_en(pc1), .ifid_en(ifid1), .idex_en(idex1),
        .exmem_en(exmem1), .memwb_en(memwb1), .ifid_flush(ifidF1), .idex_flush(idexF1)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stallCnt1), .flush_cnt(flushCnt1)
`endif
    );

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(32)) dut3 (
        .CLK(CLK), .nRST(nRST), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_lw(ex_lw), .ex_wsel(ex_wsel), .ex_pcsrc(ex_pcsrc), .ihit(ihit),
        .mem_dreq(mem_dreq), .dhit(dhit), .pc_en(pc3), .ifid_en(ifid3), .idex_en(idex3),
        .exmem_en(exmem3), .memwb_en(memwb3), .ifid_flush(ifidF3), .idex_flush(idexF3)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stallCnt3), .flush_cnt(flushCnt3)
`endif
    );

`ifdef HAZARD_PERF_EN
    hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(2)) dutSat (
        .CLK(CLK), .nRST(nRST), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_lw(ex_lw), .ex_wsel(ex_wsel), .ex_pcsrc(ex_pcsrc), .ihit(ihit),
        .mem_dreq(mem_dreq), .dhit(dhit), .pc_en(pcS), .ifid_en(ifidS), .idex_en(idexS),
        .exmem_en(exmemS), .memwb_en(memwbS), .ifid_flush(ifidFS), .idex_flush(idexFS),
        .stall_cnt(stallCntS), .flush_cnt(flushCntS)
    );
`endif

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic lw, input logic [4:0] wsel, input logic pcsrc,
                                 input logic ih, input logic dreq, input logic dh);
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        ex_lw     = lw;
        ex_wsel   = wsel;
        ex_pcsrc  = pcsrc;
        ihit      = ih;
        mem_dreq  = dreq;
        dhit      = dh;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        nRST = 1'b0;
        applyStimulus(ADDI, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        applyStimulus(ADDI, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("reset_l1", outs1, RESET);
        checkOutput("reset_l3", outs3, RESET);
        tick();
        nRST = 1'b1;
        applyStimulus(ADDI, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("idle_l1", outs1, NORMAL);
        checkOutput("idle_l3", outs3, NORMAL);

        // RTYPE rt dependency: one stall for LOAD_LAT=1, three for LOAD_LAT=3
        tick();
        applyStimulus(RTYPE, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rtype_lu_l1", outs1, LUSTL);
        checkOutput("rtype_lu_l3_c1", outs3, LUSTL);
        tick();
        applyStimulus(RTYPE, 5'd3, 5'd8, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rtype_done_l1", outs1, NORMAL);
        checkOutput("rtype_lu_l3_c2", outs3, LUSTL);
        tick();
        checkOutput("rtype_lu_l3_c3", outs3, LUSTL);
        tick();
        checkOutput("rtype_done_l3", outs3, NORMAL);

        // ADDI rs dependency with LOAD_LAT=3 and a 2-cycle data wait mid-stall
        doReset();
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("addi_lu_c1", outs3, LUSTL);
        tick();
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("addi_lu_c2", outs3, LUSTL);
        tick();
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("addi_dwait_c3", outs3, DWAIT);
        checkOutput("dwait_l1", outs1, DWAIT);
        tick();
        checkOutput("addi_dwait_c4", outs3, DWAIT);
        tick();
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("addi_lu_c5", outs3, LUSTL);
        tick();
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("addi_done_c6", outs3, NORMAL);

        // Zero register, rt-only match on I-type, and store rt dependency
        doReset();
        applyStimulus(RTYPE, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("zero_reg_l1", outs1, NORMAL);
        checkOutput("zero_reg_l3", outs3, NORMAL);
        tick();
        applyStimulus(ORI, 5'd2, 5'd4, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("ori_rt_l1", outs1, NORMAL);
        checkOutput("ori_rt_l3", outs3, NORMAL);
        tick();
        applyStimulus(SW, 5'd2, 5'd4, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("sw_rt_l1", outs1, LUSTL);

        // Branch beats load-use; data wait beats branch; fetch miss
        doReset();
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("branch_lu_l1", outs1, FLUSH);
        checkOutput("branch_lu_l3", outs3, FLUSH);
        tick();
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("branch_after_l3", outs3, NORMAL);
        tick();
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("dwait_over_branch", outs3, DWAIT);
        tick();
        applyStimulus(ADDI, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fetch_miss_l1", outs1, FMISS);
        tick();
        applyStimulus(ADDI, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("fetch_miss_dhit_l3", outs3, FMISS);

        // Reset asserted inside LU_STALL with cnt=2
        doReset();
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_mid_c1", outs3, LUSTL);
        tick();
        nRST = 1'b0;
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_mid_asserted", outs3, RESET);
        tick();
        nRST = 1'b1;
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_mid_release", outs3, NORMAL);
        tick();
        checkOutput("rst_mid_after", outs3, NORMAL);

`ifdef HAZARD_PERF_EN
        // Three load-use stall cycles then one branch flush
        doReset();
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(ADDI, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(ADDI, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(ADDI, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCount("stall_cnt_l3", stallCnt3, 32'd3);
        checkCount("flush_cnt_l3", flushCnt3, 32'd1);
        checkCount("stall_cnt_l1", stallCnt1, 32'd1);

        // Five fetch-miss cycles saturate a 2-bit counter
        doReset();
        applyStimulus(ADDI, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        applyStimulus(ADDI, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCount("stall_cnt_sat", {30'd0, stallCntS}, 32'd3);
        checkCount("stall_cnt_wide", stallCnt3, 32'd5);
        checkCount("flush_cnt_cleared", flushCnt3, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage MIPS core. It detects load-use dependencies, holds the front end for a configurable number of load-latency cycles, and freezes the whole pipeline while data memory is waiting. It also squashes wrong-path instructions on taken branches and jumps. Sits beside the datapath and drives the enable and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB; replaces the single-cycle combinational load-use stall logic.

## Interface
- REG_W, 5: register-select width.
- LOAD_LAT, 1: load-use stall cycles, legal 1..4.
- CNT_W, 32: width of performance counters.
- CLK in 1: core clock, rising edge.
- nRST in 1: reset, synchronous, active-low.
- id_opcode in 6: opcode of the instruction in ID.
- id_rs, id_rt in REG_W: source registers in ID.
- ex_lw in 1: the EX instruction is a load.
- ex_wsel in REG_W: destination register of the EX instruction.
- ex_pcsrc in 1: taken branch or jump resolved in EX.
- ihit in 1: instruction fetch complete this cycle.
- mem_dreq in 1: MEM stage has a data read or write pending.
- dhit in 1: data access complete this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en out 1: register enables.
- ifid_flush, idex_flush out 1: load a bubble on the next edge.
- stall_cnt, flush_cnt out CNT_W: performance counters; present only with HAZARD_PERF_EN.

## Operation
- Dependency rule:
  - RTYPE, BEQ and BNE read rs and rt.
  - I-type ALU ops (ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI), loads and stores read rs only. Stores also read rt.
  - A register field equal to 0 never creates a dependency.
  - lu_hit = ex_lw and (ex_wsel matches a read source).
- Conditions are listed in priority order; the highest one true decides the outputs.
- dwait = mem_dreq and not dhit:
  - All enables 0, no flush.
  - The FSM state and the stall counter are held.
- ex_pcsrc:
  - ifid_flush=1 and idex_flush=1; all enables 1.
  - FSM goes to RUN and the counter clears.
  - The flush overrides a simultaneous lu_hit, because the dependent instruction is wrong-path.
- Load-use stall (lu_hit in RUN, or state LU_STALL):
  - pc_en=0, ifid_en=0, idex_flush=1.
  - exmem_en=1, memwb_en=1.
- Not ihit (fetch miss):
  - pc_en=0, ifid_flush=1.
  - All other enables 1.
- Otherwise all enables 1 and both flushes 0.
- FSM states:
  - RUN: on lu_hit, if LOAD_LAT>1 go to LU_STALL and load cnt=LOAD_LAT-1; otherwise stay in RUN (single-cycle stall).
  - LU_STALL: cnt decrements on each cycle that is not dwait. Return to RUN on the edge where cnt==1 decrements.
- The counter is width ceil(log2(LOAD_LAT+1)) and never wraps below 0.

## Timing
- Every stall and flush output is combinational from the inputs and the registered state, in the same cycle.
- The load-use penalty is exactly LOAD_LAT cycles, plus any dwait cycles.
- The branch penalty is 2 bubbles.
- State and counters update on the rising edge of CLK.
- While nRST=0:
  - All enables 0, all flushes 0.
  - The state is RUN, cnt=0, and the counters are 0, all applied on the next edge.
- Reset asserted in LU_STALL returns the FSM to RUN with no residual stall.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments on every cycle with pc_en=0 and nRST=1.
  - flush_cnt increments on every cycle with ex_pcsrc=1 and not dwait.
  - Both counters saturate at all-ones.
- HAZARD_PERF_EN undefined: stall_cnt and flush_cnt are not ports, and no counter registers are built.

## Structure
- cpu_types_pkg holds:
  - The opcode enum (already present).
  - The hazard_state_t enum {RUN, LU_STALL}.
  - The function reads_rt(opcode) and the function reads_rs(opcode).
- hazard_unit_if gains the new signals; hazard_ctrl uses the hu modport.
- One sub-module, hazard_detect: the purely combinational dependency check that produces lu_hit.

## Test plan
- RTYPE dependency: ex_lw=1, ex_wsel=8, RTYPE with id_rt=8, LOAD_LAT=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal.
- Longer latency: LOAD_LAT=3, ADDI with id_rs=9, ex_wsel=9 -> 3 stall cycles. Add dhit=0 for 2 cycles mid-stall -> 5 cycles total, with all enables 0 during the wait.
- Zero register and rt-only match: ex_wsel=0 with id_rs=0 -> no stall. ORI with id_rt=ex_wsel=4 and id_rs≠4 -> no stall.
- Branch beats load-use: ex_pcsrc=1 together with lu_hit -> ifid_flush=1, idex_flush=1, pc_en=1, state RUN.
- Reset mid-stall: nRST=0 during LU_STALL with cnt=2 -> next cycle state RUN, and after release pc_en=1 with no stall.
- Counters (HAZARD_PERF_EN): 3 stall cycles plus 1 flush -> stall_cnt=3, flush_cnt=1. With CNT_W=2, 5 stall cycles -> stall_cnt=3 (saturated).
